// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: state encoding, default width and
// the iteration-counter width helper.
package divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StCalc = ST_CALC,
    StDone = ST_DONE
  } state_e;

  // Counter must hold 0..width inclusive.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned DEFAULT_CNT_WIDTH = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem, quo}, trial subtract,
// keep or restore the partial remainder and shift in the quotient bit.
module div_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH:0]   trial;

  assign {rem_sh, quo_sh} = {rem, quo} << 1;
  assign trial            = {1'b0, rem_sh} - {1'b0, divisor};

  // trial MSB set means the subtraction borrowed: restore and emit a 0 bit.
  assign rem_nxt = trial[WIDTH] ? rem_sh : trial[WIDTH-1:0];
  assign quo_nxt = {quo_sh[WIDTH-1:1], ~trial[WIDTH]};

endmodule

// File: rtl/divider4b.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Optional early divide-by-zero exit enabled by defining DIVIDER4B_DIV0_EN.
module divider4b
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic             div0_q, div0_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nxt (step_rem),
    .quo_nxt (step_quo)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    div0_d  = div0_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          quo_d   = A;
          dvs_d   = B;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = StCalc;
`ifdef DIVIDER4B_DIV0_EN
          if (B == '0) begin
            state_d = StDone;
            q_out_d = '1;
            r_out_d = A;
            div0_d  = 1'b1;
          end
`endif
        end
      end
      StCalc: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          q_out_d = step_quo;
          r_out_d = step_rem;
          div0_d  = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      div0_q  <= div0_d;
    end
  end

  assign Q    = q_out_q;
  assign R    = r_out_q;
  assign busy = (state_q == StCalc);
  assign done = (state_q == StDone);
  assign div0 = div0_q;

endmodule

// File: tb/tb_divider4b.sv
// Directed self-checking bench for divider4b with hand-computed quotient/remainder.
module tb_divider4b;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       div0;

  int n_cmp = 0;
  int n_err = 0;

  divider4b dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .div0  (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one division and follow it to done, checking latency and busy width.
  task automatic run_div(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input int exp_lat, input int exp_busy);
    int n;
    int busy_cnt;
    int overlap;
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    busy_cnt = 0;
    overlap = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      tick();
      n++;
    end
    if (busy && done) overlap = 1;
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " busy cycles"}, busy_cnt, exp_busy);
    chk({tag, " busy&done"}, overlap, 0);
  endtask

  task automatic chk_result(input string tag, input int q, input int r, input int d0);
    chk({tag, " Q"}, int'(Q), q);
    chk({tag, " R"}, int'(R), r);
    chk({tag, " div0"}, int'(div0), d0);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    start = 1'b0;
    A = 4'($urandom_range(0, 15));
    B = 4'($urandom_range(0, 15));
    #12;
    chk("reset Q", int'(Q), 0);
    chk("reset R", int'(R), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset div0", int'(div0), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle busy", int'(busy), 0);
    chk("idle done", int'(done), 0);

    run_div("13/3", 4'd13, 4'd3, 4, 4);
    chk_result("13/3", 4, 1, 0);
    tick();
    chk("13/3 done pulse width", int'(done), 0);

    run_div("15/15", 4'd15, 4'd15, 4, 4);
    chk_result("15/15", 1, 0, 0);
    repeat (3) tick();
    chk_result("15/15 hold", 1, 0, 0);
    run_div("7/9", 4'd7, 4'd9, 4, 4);
    chk_result("7/9", 0, 7, 0);
    repeat (2) tick();
    chk_result("7/9 hold", 0, 7, 0);
    run_div("15/1", 4'd15, 4'd1, 4, 4);
    chk_result("15/1", 15, 0, 0);
    tick();

`ifdef DIVIDER4B_DIV0_EN
    run_div("9/0", 4'd9, 4'd0, 0, 0);
    chk_result("9/0", 15, 9, 1);
`else
    run_div("9/0", 4'd9, 4'd0, 4, 4);
    chk_result("9/0", 15, 9, 0);
`endif
    tick();

    // Start pulsed during CALC must be ignored.
    A = 4'd12;
    B = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    A = 4'd3;
    B = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !done; i++) tick();
    chk("ignore done seen", int'(done), 1);
    chk_result("ignore 12/5", 2, 2, 0);
    tick();
    chk("ignore no restart", int'(busy), 0);

    // Reset in the middle of CALC aborts with no done pulse.
    A = 4'd14;
    B = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk_result("abort", 0, 0, 0);
    chk("abort busy", int'(busy), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) seen++;
      tick();
    end
    chk("abort no done", seen, 0);
    run_div("post-abort 12/5", 4'd12, 4'd5, 4, 4);
    chk_result("post-abort 12/5", 2, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
